// File: rtl/mult_pkg.sv
// Shared types for the sequential shift-and-add multiplier.
// Holds the FSM state encoding and the supported width limit.
package mult_pkg;

  localparam int MULT_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/ripple_add.sv
// WIDTH-bit ripple-carry adder with carry out, carry in tied to zero.
// Used once per iteration to fold the multiplicand into the high half.
module ripple_add
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier, one iteration per operand bit.
// Define MULT_SIGNED_EN for two's complement operands and product.
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  mult_state_e        state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [2*WIDTH-1:0] p_q;
  logic [2*WIDTH-1:0] result;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               last;

  assign addend = prod_q[0] ? mcand_q : '0;

  ripple_add #(
    .WIDTH (WIDTH)
  ) u_add (
    .a    (prod_q[2*WIDTH-1:WIDTH]),
    .b    (addend),
    .sum  (sum),
    .cout (cout)
  );

  // Carry lands in the top bit so the shifted product never overflows.
  assign prod_nxt = {cout, sum, prod_q[WIDTH-1:1]};
  assign last     = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MULT_SIGNED_EN
  logic neg_q;

  // -2^(W-1) negates to itself, which reads correctly as an unsigned magnitude.
  assign a_mag  = a[WIDTH-1] ? -a : a;
  assign b_mag  = b[WIDTH-1] ? -b : b;
  assign result = neg_q ? -prod_nxt : prod_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
    end
  end
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign result = prod_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q <= a_mag;
            prod_q  <= {{WIDTH{1'b0}}, b_mag};
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          prod_q <= prod_nxt;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last) begin
            p_q     <= result;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign p         = p_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed and sweep bench for seq_shift_add_mult at widths 8, 4 and 16.
// Expected values follow MULT_SIGNED_EN when it is defined.
module tb_seq_shift_add_mult;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic        iv8 = 0, ir8, ov8, or8 = 0, busy8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] p8;

  logic        iv4 = 0, ir4, ov4, or4 = 0, busy4;
  logic [3:0]  a4 = 0, b4 = 0;
  logic [7:0]  p4;

  logic        iv16 = 0, ir16, ov16, or16 = 0, busy16;
  logic [15:0] a16 = 0, b16 = 0;
  logic [31:0] p16;

  seq_shift_add_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8),
    .p(p8), .busy(busy8)
  );

  seq_shift_add_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .out_valid(ov4), .out_ready(or4),
    .p(p4), .busy(busy4)
  );

  seq_shift_add_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .out_valid(ov16), .out_ready(or16),
    .p(p16), .busy(busy16)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    string       name;
  } vec_t;

  vec_t tbl[6];

  function automatic logic [63:0] ref_mul(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input int w);
    longint sx, sy;
    logic [63:0] m;
    m  = (64'd1 << (2 * w)) - 64'd1;
    sx = longint'(x);
    sy = longint'(y);
`ifdef MULT_SIGNED_EN
    if (x[w-1]) sx = sx - (longint'(1) << w);
    if (y[w-1]) sy = sy - (longint'(1) << w);
`endif
    return 64'(sx * sy) & m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb,
                        input logic [15:0] tp, input string nm,
                        input bit stall);
    int n;
    n = 0;
    while (!ir8 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    a8 = ta; b8 = tb; iv8 = 1; or8 = !stall;
    @(posedge clk); #1;
    iv8 = 0; a8 = ~ta; b8 = 8'h5a;
    n = 0;
    while (!ov8 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, " latency"}, 64'(n), 64'd8);
    chk({nm, " p"}, 64'(p8), 64'(tp));
    if (stall) begin
      for (int k = 0; k < 20; k++) begin
        iv8 = (k % 3 == 0); a8 = 8'(k); b8 = 8'(k + 7);
        @(posedge clk); #1;
        chk({nm, " stall hold"}, {ov8, ir8, busy8, p8}, {3'b100, tp});
      end
      iv8 = 1; or8 = 1;
    end
    @(posedge clk); #1;
    iv8 = 0;
    chk({nm, " release"}, {ov8, ir8, busy8}, 3'b010);
    or8 = 0;
  endtask

  task automatic sweep4();
    logic [7:0] exp_q[$];
    int got_n;
    got_n = 0;
    fork
      begin
        int g;
        logic h;
        for (int i = 0; i < 256; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          a4 = 4'(i); b4 = 4'(i >> 4); iv4 = 1;
          for (g = 0; g < 100; g++) begin
            h = ir4;
            @(posedge clk); #1;
            if (h) break;
          end
          if (g == 100) chk("w4 accept timeout", 64'd0, 64'd1);
          exp_q.push_back(8'(ref_mul(32'(a4), 32'(b4), 4)));
          iv4 = 0;
        end
      end
      begin
        int g;
        for (g = 0; g < 20000 && got_n < 256; g++) begin
          or4 = 1'($urandom_range(0, 1));
          if (ov4 && or4) begin
            if (exp_q.size() == 0) chk("w4 extra output", 64'(p4), 64'hx);
            else chk("w4 sweep p", 64'(p4), 64'(exp_q.pop_front()));
            got_n++;
          end
          @(posedge clk); #1;
        end
        if (got_n < 256) chk("w4 result count", 64'(got_n), 64'd256);
        or4 = 0;
      end
    join
  endtask

  task automatic sweep16();
    logic [31:0] exp_q[$];
    int got_n;
    got_n = 0;
    fork
      begin
        int g;
        logic h;
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          if (i == 0) begin a16 = 16'hffff; b16 = 16'hffff; end
          else if (i == 1) begin a16 = 16'h8000; b16 = 16'h8000; end
          else begin a16 = 16'($urandom); b16 = 16'($urandom); end
          iv16 = 1;
          for (g = 0; g < 100; g++) begin
            h = ir16;
            @(posedge clk); #1;
            if (h) break;
          end
          if (g == 100) chk("w16 accept timeout", 64'd0, 64'd1);
          exp_q.push_back(32'(ref_mul(32'(a16), 32'(b16), 16)));
          iv16 = 0;
        end
      end
      begin
        int g;
        for (g = 0; g < 20000 && got_n < 40; g++) begin
          or16 = 1'($urandom_range(0, 1));
          if (ov16 && or16) begin
            if (exp_q.size() == 0) chk("w16 extra output", 64'(p16), 64'hx);
            else chk("w16 sweep p", 64'(p16), 64'(exp_q.pop_front()));
            got_n++;
          end
          @(posedge clk); #1;
        end
        if (got_n < 40) chk("w16 result count", 64'(got_n), 64'd40);
        or16 = 0;
      end
    join
  endtask

  initial begin
    int t0, t1, n;
    logic h;
`ifdef MULT_SIGNED_EN
    tbl[0] = '{8'hfd, 8'h05, 16'hfff1, "neg3x5"};
    tbl[1] = '{8'h80, 8'h80, 16'h4000, "min_x_min"};
    tbl[2] = '{8'h80, 8'h7f, 16'hc080, "min_x_max"};
    tbl[3] = '{8'hff, 8'hff, 16'h0001, "m1_x_m1"};
    tbl[4] = '{8'h00, 8'ha5, 16'h0000, "zero_a"};
    tbl[5] = '{8'ha5, 8'h00, 16'h0000, "zero_b"};
`else
    tbl[0] = '{8'hff, 8'hff, 16'hfe01, "ff_x_ff"};
    tbl[1] = '{8'h00, 8'ha5, 16'h0000, "zero_a"};
    tbl[2] = '{8'ha5, 8'h00, 16'h0000, "zero_b"};
    tbl[3] = '{8'h80, 8'h80, 16'h4000, "80_x_80"};
    tbl[4] = '{8'hfd, 8'h05, 16'h04f1, "fd_x_05"};
    tbl[5] = '{8'h80, 8'h7f, 16'h3f80, "80_x_7f"};
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset state", {ir8, ov8, busy8, p8}, {3'b100, 16'h0});
    rst = 0;

    foreach (tbl[i]) do_op8(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].name, 0);

    do_op8(8'd13, 8'd11, 16'h008f, "stall_13x11", 1);

    a8 = 8'd5; b8 = 8'd6; iv8 = 1; or8 = 1;
    t0 = 0; t1 = 0;
    for (n = 0; n < 50; n++) begin
      h = ir8; @(posedge clk); #1;
      if (h) break;
    end
    t0 = cyc;
    a8 = 8'd7; b8 = 8'd9;
    for (n = 0; n < 50; n++) begin
      h = ir8; @(posedge clk); #1;
      if (h) break;
    end
    t1 = cyc;
    iv8 = 0;
    chk("b2b interval", 64'(t1 - t0), 64'd10);
    for (n = 0; n < 40 && !ov8; n++) begin @(posedge clk); #1; end
    chk("b2b second p", 64'(p8), 64'h3f);
    @(posedge clk); #1;
    or8 = 0;

    a8 = 8'hff; b8 = 8'hff; iv8 = 1;
    @(posedge clk); #1;
    iv8 = 0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk("async reset", {ir8, ov8, busy8, p8}, {3'b100, 16'h0});
    @(posedge clk); #1;
    rst = 0;
    do_op8(8'd2, 8'd3, 16'd6, "after_reset", 0);

    sweep4();
    sweep16();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
